// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multiply/divide unit.
//   mdu_op_t    - operation code driven on the MDU issue port
//   mdu_state_t - sequencer state of mdu_iter
//   div_cycles  - total divide latency for a given operand width
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } mdu_state_t;

    // One cycle to load the divider core, WIDTH iterations, one cycle of sign fix-up.
    function automatic int div_cycles(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the EX stage and the MDU.
//   op, start, d1, d2 : issue side (driven by master)
//   busy, done, hi, lo: status and HI/LO registers (driven by slave)
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    mdu_op_t            op;
    logic               start;
    logic [WIDTH-1:0]   d1;
    logic [WIDTH-1:0]   d2;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (output op, start, d1, d2, input busy, done, hi, lo);
    modport slave  (input op, start, d1, d2, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned radix-2 restoring divider, one quotient bit per step.
//   clk, reset (async, active-low)
//   load      : capture dividend/divisor, clear partial remainder
//   step      : perform one restoring iteration
//   dividend, divisor : unsigned operands (sampled on load)
//   quotient, remainder : valid after WIDTH steps
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;

    // Dividend bits shift out of the top of q_q into the remainder while
    // quotient bits shift in at the bottom.
    assign r_sh  = {r_q, q_q[WIDTH-1]};
    assign trial = r_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            r_q   <= '0;
            dvs_q <= '0;
        end else if (load) begin
            q_q   <= dividend;
            r_q   <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            if (trial[WIDTH]) begin
                r_q <= r_sh[WIDTH-1:0];
                q_q <= {q_q[WIDTH-2:0], 1'b0};
            end else begin
                r_q <= trial[WIDTH-1:0];
                q_q <= {q_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mdu_if.slave - op/start/d1/d2 in; busy/done/hi/lo out
// Multiply results land MUL_CYCLES after accept, divides div_cycles(WIDTH)
// after accept; done pulses for the cycle after the result lands.
// Build option: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (accumulate into
// {hi,lo}); without it those codes are ignored like NOP.
//
// state    | meaning
// IDLE     | waiting for an op; MTHI/MTLO handled here
// MUL      | counting down multiply latency
// DIV_ITER | first cycle loads divider core, then WIDTH restoring steps
// DIV_FIX  | apply signs / divide-by-zero result, write HI/LO
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(div_cycles(WIDTH) - 2);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);

    function automatic logic is_long_op(input mdu_op_t o);
`ifdef MDU_MADD_EN
        return o inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
`else
        return o inside {MULT, MULTU, DIV, DIVU};
`endif
    endfunction

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    mdu_op_t            op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               done_q;
    logic               accept, core_load, core_step;
    logic               a_neg, b_neg, div_zero, signed_mul;
    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem, quot_s, rem_s;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;

    assign accept = bus.start && (state_q == IDLE) && is_long_op(bus.op);

    // Magnitudes come from the captured operands so the abs/negate logic is
    // off the issue path; MIN stays MIN and is correct as an unsigned value.
    assign a_neg    = (op_q == DIV) && a_q[WIDTH-1];
    assign b_neg    = (op_q == DIV) && b_q[WIDTH-1];
    assign a_mag    = a_neg ? -a_q : a_q;
    assign b_mag    = b_neg ? -b_q : b_q;
    assign div_zero = (b_q == '0);
    assign quot_s   = (a_neg ^ b_neg) ? -quot : quot;
    assign rem_s    = a_neg ? -rem : rem;

    // Extending both operands to 2*WIDTH gives the exact product modulo 2^(2*WIDTH).
    assign signed_mul = op_q inside {MULT, MADD, MSUB};
    assign a_ext = signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quot),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        mul_res   = prod;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.op inside {DIV, DIVU}) ? DIV_ITER : MUL;
                end
            end
            MUL: begin
                if (cnt_q == '0) state_d = IDLE;
            end
            DIV_ITER: begin
                core_load = (cnt_q == CNT_DIV);
                core_step = (cnt_q != CNT_DIV);
                if (cnt_q == '0) state_d = DIV_FIX;
            end
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef MDU_MADD_EN
        if (op_q inside {MADD, MADDU}) begin
            mul_res = {hi_q, lo_q} + prod;
        end else if (op_q inside {MSUB, MSUBU}) begin
            mul_res = {hi_q, lo_q} - prod;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            op_q   <= NOP;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) && bus.start) begin
                if (bus.op == MTHI) hi_q <= bus.d1;
                if (bus.op == MTLO) lo_q <= bus.d1;
            end
            if (accept) begin
                op_q  <= bus.op;
                a_q   <= bus.d1;
                b_q   <= bus.d2;
                cnt_q <= (bus.op inside {DIV, DIVU}) ? CNT_DIV : CNT_MUL;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if ((state_q == MUL) && (cnt_q == '0)) begin
                {hi_q, lo_q} <= mul_res;
                done_q       <= 1'b1;
            end
            if (state_q == DIV_FIX) begin
                if (div_zero) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= rem_s;
                    lo_q <= quot_s;
                end
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + random bench for mdu_iter (WIDTH=32, MUL_CYCLES=5).
// Expected {hi,lo} pairs are queued at issue and popped when done pulses.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [63:0] scoreboard[$];

    mdu_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        res = '0;
        case (op)
            MULT:  res = 64'(sa * sbv);
            MULTU: res = {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input bit disturb);
        int n;
        logic [63:0] e;
        @(negedge clk);
        bus.op = op; bus.start = 1'b1; bus.d1 = a; bus.d2 = b;
        scoreboard.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = NOP;
        chk({tag, ".busy_on_accept"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (disturb && n == 3) begin
                bus.op = MTLO; bus.d1 = 32'hDEADBEEF; bus.start = 1'b1;
            end else if (disturb && n == 6) begin
                bus.op = MULT; bus.d1 = 32'd3; bus.d2 = 32'd3; bus.start = 1'b1;
            end else begin
                bus.op = NOP; bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (bus.busy === 1'b1) chk({tag, ".done_while_busy"}, 64'(bus.done), 64'd0);
        end
        bus.op = NOP; bus.start = 1'b0;
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'd1);
        e = scoreboard.pop_front();
        chk({tag, ".hi"}, 64'(bus.hi), 64'(e[63:32]));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(e[31:0]));
        @(posedge clk); #1;
        chk({tag, ".done_cleared"}, 64'(bus.done), 64'd0);
    endtask

    task automatic move_to(input mdu_op_t op, input logic [31:0] val);
        @(negedge clk);
        bus.op = op; bus.start = 1'b1; bus.d1 = val;
        @(posedge clk); #1;
        bus.op = NOP; bus.start = 1'b0;
    endtask

    initial begin
        bus.op = NOP; bus.start = 1'b0; bus.d1 = '0; bus.d2 = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.done", 64'(bus.done), 64'd0);
        chk("reset.hi",   64'(bus.hi),   64'd0);
        chk("reset.lo",   64'(bus.lo),   64'd0);
        @(negedge clk) reset = 1'b1;

        run_op("mult_m1x2",  MULT,  32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 5, 1'b0);
        run_op("multu_m1x2", MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1'b0);
        run_op("div_m7_2",   DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        run_op("divu_7_2",   DIVU,  32'd7, 32'd2, 64'h00000001_00000003, 34, 1'b0);
        run_op("divu_5_0",   DIVU,  32'd5, 32'd0, 64'h00000005_FFFFFFFF, 34, 1'b0);
        run_op("div_min_m1", DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
        run_op("div_7_m2",   DIV,   32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);
        run_op("div_m7_m2",  DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34, 1'b0);
        run_op("div_m5_0",   DIV,   32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 34, 1'b0);

        for (int i = 0; i < 8; i++) begin
            mdu_op_t rop;
            logic [31:0] ra, rb;
            case ($urandom_range(0, 3))
                0:       rop = MULT;
                1:       rop = MULTU;
                2:       rop = DIV;
                default: rop = DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(1, 50);
            if (i == 3) rb = 32'd0;
            run_op("random", rop, ra, rb, model(rop, ra, rb),
                   (rop inside {DIV, DIVU}) ? 34 : 5, 1'b0);
        end

        @(negedge clk);
        bus.op = MTHI; bus.start = 1'b1; bus.d1 = 32'h1234;
        @(posedge clk); #1;
        bus.op = NOP; bus.start = 1'b0;
        chk("mthi.hi",   64'(bus.hi),   64'h1234);
        chk("mthi.busy", 64'(bus.busy), 64'd0);
        chk("mthi.done", 64'(bus.done), 64'd0);
        move_to(MTLO, 32'h5678);
        chk("mtlo.lo",   64'(bus.lo),   64'h5678);
        chk("mtlo.busy", 64'(bus.busy), 64'd0);

        run_op("div_disturbed", DIV, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b1);

        @(negedge clk);
        bus.op = DIV; bus.start = 1'b1; bus.d1 = 32'd1000; bus.d2 = 32'd7;
        scoreboard.push_back(model(DIV, 32'd1000, 32'd7));
        @(posedge clk); #1;
        bus.op = NOP; bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset.busy", 64'(bus.busy), 64'd0);
        chk("midreset.done", 64'(bus.done), 64'd0);
        chk("midreset.hi",   64'(bus.hi),   64'd0);
        chk("midreset.lo",   64'(bus.lo),   64'd0);
        scoreboard.delete();
        @(negedge clk) reset = 1'b1;
        run_op("mult_after_reset", MULT, 32'd6, 32'hFFFFFFF9,
               model(MULT, 32'd6, 32'hFFFFFFF9), 5, 1'b0);

        move_to(MTHI, 32'd0);
        move_to(MTLO, 32'd5);
`ifdef MDU_MADD_EN
        run_op("madd_3x4",    MADD,  32'd3, 32'd4,  64'h00000000_00000011, 5, 1'b0);
        run_op("msubu_1x18",  MSUBU, 32'd1, 32'd18, 64'hFFFFFFFF_FFFFFFFF, 5, 1'b0);
`else
        @(negedge clk);
        bus.op = MADD; bus.start = 1'b1; bus.d1 = 32'd3; bus.d2 = 32'd4;
        @(posedge clk); #1;
        bus.op = NOP; bus.start = 1'b0;
        chk("madd_off.busy", 64'(bus.busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("madd_off.busy_hold", 64'(bus.busy), 64'd0);
            chk("madd_off.done",      64'(bus.done), 64'd0);
        end
        chk("madd_off.hi", 64'(bus.hi), 64'd0);
        chk("madd_off.lo", 64'(bus.lo), 64'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
